// File: rtl/noc_pkg.sv
// noc_pkg: shared router direction codes and sizing constants
package noc_pkg;
  typedef enum logic [2:0] {
    DIR_N = 3'd0,
    DIR_S = 3'd1,
    DIR_E = 3'd2,
    DIR_W = 3'd3,
    DIR_L = 3'd4,
    DIR_INVALID = 3'd7
  } dir_t;
  localparam int NOC_DSIZE = 32;
  localparam int NOC_PORTS = 5;
endpackage

// File: rtl/output_fifo.sv
// output_fifo: small synchronous FIFO with MSB-wrap pointers; head word reads 0 when empty
module output_fifo #(
  parameter int DSIZE = 32,
  parameter int OUT_ADDRSIZE = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [DSIZE-1:0]        i_data,
  output logic [DSIZE-1:0]        o_data,
  output logic [OUT_ADDRSIZE:0]   o_count,
  output logic                    o_full,
  output logic                    o_empty
);
  localparam logic [OUT_ADDRSIZE:0] L_ONE = 1;
  logic [DSIZE-1:0] r_mem [1<<OUT_ADDRSIZE];
  logic [OUT_ADDRSIZE:0] r_wr, r_rd;
  // read/write pointers; push and pop may both happen in one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + L_ONE;
      if (i_pop) r_rd <= r_rd + L_ONE;
    end
  end
  // storage is not reset; emptiness is tracked by the pointers alone
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr[OUT_ADDRSIZE-1:0]] <= i_data;
  end
  assign o_count = r_wr - r_rd;
  assign o_empty = r_wr == r_rd;
  assign o_full  = (r_wr[OUT_ADDRSIZE] != r_rd[OUT_ADDRSIZE]) && (r_wr[OUT_ADDRSIZE-1:0] == r_rd[OUT_ADDRSIZE-1:0]);
  assign o_data  = o_empty ? '0 : r_mem[r_rd[OUT_ADDRSIZE-1:0]];
endmodule

// File: rtl/output_module.sv
// output_module: round-robin arbiter over input VCs feeding an output FIFO; OUTPUT_MODULE_STATS_EN adds flit/stall counters
module output_module
  import noc_pkg::*;
#(
  parameter int DSIZE = NOC_DSIZE,
  parameter int PORT = 0,
  parameter int OUT_ADDRSIZE = 2,
  parameter int OUT_DEPTH = 1 << OUT_ADDRSIZE
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NOC_PORTS-1:0]         req,
  input  logic [NOC_PORTS*DSIZE-1:0]   data_in,
  output logic [NOC_PORTS-1:0]         read_en,
  output logic [DSIZE-1:0]             data_out,
  output logic                         out_valid,
  input  logic                         down_full,
  output logic                         out_write,
`ifdef OUTPUT_MODULE_STATS_EN
  output logic [15:0]                  flit_count,
  output logic [15:0]                  stall_count,
`endif
  output logic [OUT_ADDRSIZE:0]        occupancy
);
  localparam logic [NOC_PORTS-1:0] L_MASK = ~(NOC_PORTS'(1) << PORT);
  localparam logic [OUT_ADDRSIZE:0] L_DEPTH = (OUT_ADDRSIZE+1)'(OUT_DEPTH);
  logic [2:0] r_ptr, r_sel, w_sel, w_idx, w_next;
  logic r_inflight, w_room, w_gnt, w_full, w_empty;
  logic [NOC_PORTS-1:0] w_req;
  logic [DSIZE-1:0] w_push_data;
  assign w_req = req & L_MASK;
  // a flit already popped from a VC holds a FIFO slot until it lands
  assign w_room = (occupancy + {{OUT_ADDRSIZE{1'b0}}, r_inflight}) < L_DEPTH;
  assign w_gnt = (|w_req) & w_room & ~reset;
  // scan backwards from the farthest slot so the first requester after r_ptr wins
  always_comb begin
    w_sel = r_ptr;
    w_idx = '0;
    for (int k = NOC_PORTS-1; k >= 0; k--) begin
      w_idx = 3'((int'(r_ptr) + k) % NOC_PORTS);
      w_sel = w_req[w_idx] ? w_idx : w_sel;
    end
  end
  assign w_next = (w_sel == 3'(DIR_L)) ? 3'(DIR_N) : w_sel + 3'd1;
  assign read_en = w_gnt ? NOC_PORTS'(1) << w_sel : '0;
  // pointer advances past the winner; inflight marks VC data arriving next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= 3'(DIR_N);
      r_sel <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_gnt;
      if (w_gnt) begin
        r_ptr <= w_next;
        r_sel <= w_sel;
      end
    end
  end
  // select the VC read data of the port granted last cycle
  always_comb begin
    w_push_data = '0;
    for (int i = 0; i < NOC_PORTS; i++) w_push_data = (r_sel == 3'(i)) ? data_in[i*DSIZE +: DSIZE] : w_push_data;
  end
  output_fifo #(.DSIZE(DSIZE), .OUT_ADDRSIZE(OUT_ADDRSIZE)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_inflight),
    .i_pop   (out_write),
    .i_data  (w_push_data),
    .o_data  (data_out),
    .o_count (occupancy),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  assign out_valid = ~w_empty;
  assign out_write = out_valid & ~down_full;
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(r_inflight && w_full));
`ifdef OUTPUT_MODULE_STATS_EN
  // saturating transfer and stall counters
  always_ff @(posedge clk) begin
    if (reset) begin
      flit_count <= '0;
      stall_count <= '0;
    end else begin
      if (out_write && flit_count != 16'hFFFF) flit_count <= flit_count + 16'd1;
      if (out_valid && down_full && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_output_module.sv
// tb_output_module: directed self-checking bench for output_module (PORT=E)
module tb_output_module;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] req = '0;
  logic [5*DW-1:0] data_in = '0;
  logic [4:0] read_en;
  logic [DW-1:0] data_out;
  logic out_valid;
  logic down_full = 1'b0;
  logic out_write;
  logic [2:0] occupancy;
`ifdef OUTPUT_MODULE_STATS_EN
  logic [15:0] flit_count, stall_count;
`endif
  int checks = 0;
  int errors = 0;
  int pulses;
  int g [8] = '{0, 1, 3, 4, 0, 1, 3, 4};
  always #5 clk = ~clk;
  output_module #(.DSIZE(DW), .PORT(2), .OUT_ADDRSIZE(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data_in   (data_in),
    .read_en   (read_en),
    .data_out  (data_out),
    .out_valid (out_valid),
    .down_full (down_full),
    .out_write (out_write),
`ifdef OUTPUT_MODULE_STATS_EN
    .flit_count  (flit_count),
    .stall_count (stall_count),
`endif
    .occupancy (occupancy)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    req = '0;
    down_full = 1'b0;
    tick;
    tick;
    reset = 1'b0;
  endtask
  initial begin
    req = 5'b00001;
    #1;
    check("rst_read_en", 32'(read_en), 32'h0);
    tick;
    tick;
    reset = 1'b0;
    req = '0;
    #1;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_occ", 32'(occupancy), 32'h0);
    check("rst_write", 32'(out_write), 32'h0);
    check("rst_data", data_out, 32'h0);
    tick;
    data_in[31:0] = 32'hA5A5_0001;
    req = 5'b00001;
    #1;
    check("single_gnt", 32'(read_en), 32'h1);
    tick;
    req = '0;
    #1;
    check("single_gnt_off", 32'(read_en), 32'h0);
    check("single_t1_valid", 32'(out_valid), 32'h0);
    tick;
    check("single_t2_valid", 32'(out_valid), 32'h1);
    check("single_data", data_out, 32'hA5A5_0001);
    check("single_write", 32'(out_write), 32'h1);
    check("single_occ", 32'(occupancy), 32'h1);
    tick;
    check("single_empty", 32'(out_valid), 32'h0);
    do_reset;
    for (int i = 0; i < 5; i++) data_in[i*DW +: DW] = 32'hD000_0000 | i;
    req = 5'b11011;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("fair_gnt", 32'(read_en), 32'(1) << g[k]);
      if (k >= 2) begin
        check("fair_data", data_out, 32'hD000_0000 | g[k-2]);
        check("fair_occ", 32'(occupancy), 32'h1);
      end
      tick;
    end
    req = '0;
    tick;
    tick;
    tick;
    do_reset;
    down_full = 1'b1;
    pulses = 0;
    for (int j = 0; j < 8; j++) begin
      data_in[31:0] = 32'hB000_0000 + j;
      req = 5'b00001;
      #1;
      pulses += int'(read_en[0]);
      tick;
    end
    #1;
    check("bp_pulses", pulses, 32'd4);
    check("bp_read_en", 32'(read_en), 32'h0);
    check("bp_occ", 32'(occupancy), 32'd4);
    check("bp_write", 32'(out_write), 32'h0);
    req = '0;
    down_full = 1'b0;
    #1;
    check("bp_drain_write", 32'(out_write), 32'h1);
    check("bp_drain_data", data_out, 32'hB000_0001);
    for (int m = 1; m < 4; m++) begin
      tick;
      check("bp_drain_write", 32'(out_write), 32'h1);
      check("bp_drain_data", data_out, 32'hB000_0001 + m);
    end
    tick;
    check("bp_drain_empty", 32'(out_valid), 32'h0);
    do_reset;
    for (int j = 0; j < 7; j++) begin
      data_in[31:0] = 32'hC000_0000 + j;
      req = (j < 3) ? 5'b00001 : 5'b00000;
      down_full = (j < 3);
      #1;
      if (j == 3) begin
        check("pp_occ3", 32'(occupancy), 32'd2);
        check("pp_write3", 32'(out_write), 32'h1);
        check("pp_data3", data_out, 32'hC000_0001);
      end
      if (j == 4) begin
        check("pp_occ4", 32'(occupancy), 32'd2);
        check("pp_data4", data_out, 32'hC000_0002);
      end
      if (j == 5) begin
        check("pp_occ5", 32'(occupancy), 32'd1);
        check("pp_data5", data_out, 32'hC000_0003);
      end
      if (j == 6) check("pp_empty", 32'(out_valid), 32'h0);
      tick;
    end
    do_reset;
    data_in[31:0] = 32'hE000_0001;
    req = 5'b00001;
    #1;
    check("mid_gnt", 32'(read_en), 32'h1);
    tick;
    reset = 1'b1;
    req = '0;
    #1;
    check("mid_rst_gnt", 32'(read_en), 32'h0);
    tick;
    reset = 1'b0;
    req = 5'b10001;
    #1;
    check("mid_valid", 32'(out_valid), 32'h0);
    check("mid_occ", 32'(occupancy), 32'h0);
    check("mid_ptr_gnt", 32'(read_en), 32'h1);
    tick;
    req = '0;
    #1;
    check("mid_no_push", 32'(out_valid), 32'h0);
    tick;
    check("mid_late_valid", 32'(out_valid), 32'h1);
    check("mid_late_data", data_out, 32'hE000_0001);
`ifdef OUTPUT_MODULE_STATS_EN
    do_reset;
    #1;
    check("st_rst_flit", 32'(flit_count), 32'h0);
    check("st_rst_stall", 32'(stall_count), 32'h0);
    data_in[31:0] = 32'hF000_0000;
    req = 5'b00001;
    tick;
    req = '0;
    tick;
    down_full = 1'b1;
    tick;
    tick;
    tick;
    down_full = 1'b0;
    for (int j = 0; j < 9; j++) begin
      req = 5'b00001;
      tick;
    end
    req = '0;
    tick;
    tick;
    tick;
    tick;
    check("st_flit", 32'(flit_count), 32'd10);
    check("st_stall", 32'(stall_count), 32'd3);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/output_module.md
Name: output_module

Overview:
- One per router output direction; sits directly downstream of the five input modules' VC buffers.
- Round-robin arbitrates among the input ports whose VC buffer for this direction is non-empty.
- Pops one flit per grant, holds it in a small output FIFO, and drives the link toward the neighbour router's input module (or the local NI) under a full/back-pressure signal.
- Packets are single DSIZE-bit flits; no wormhole locking.

Parameters:
- DSIZE, 32, flit/packet width in bits.
- PORT, 0, this output's direction code: N=0, S=1, E=2, W=3, L=4.
- OUT_ADDRSIZE, 2, log2 of output FIFO depth.
- OUT_DEPTH, 1<<OUT_ADDRSIZE, output FIFO depth; must be at least 3 for full throughput.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  5  non-empty flags from each input port's VC for this direction, {L,W,E,S,N}
- data_in  in  5*DSIZE  VC read data, slice i = input port i
- read_en  out  5  one-hot pop strobe to the granted input port's VC buffer
- data_out  out  DSIZE  head flit of the output FIFO
- out_valid  out  1  output FIFO non-empty
- down_full  in  1  downstream buffer cannot accept this cycle
- out_write  out  1  flit transferred to downstream this cycle
- occupancy  out  OUT_ADDRSIZE+1  current output FIFO count

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: read_en=0, out_valid=0, out_write=0, occupancy=0, data_out=0, RR pointer=0 (N), inflight=0. read_en is forced to 0 combinationally while reset=1.
- Masking: req[PORT] is ignored (no U-turn).
- Eligibility (grant cycle t): (occupancy + inflight) < OUT_DEPTH and masked req != 0. Reservation counts inflight, so the FIFO never overflows.
- Arbitration:
  - Scan starts at pointer p, order p, p+1, ... mod 5; first set bit wins.
  - read_en[i]=1 combinationally in cycle t.
  - Pointer becomes (i+1) mod 5 at the end of t. The pointer holds when there is no grant.
- Read latency: VC data is valid one cycle after read_en.
  - At the end of t, register inflight=1 and sel=i.
  - At the end of t+1, push data_in[sel] into the FIFO.
  - Grant-to-out_valid latency is 2 cycles.
- Drain: out_write = out_valid & !down_full. When out_write=1, the FIFO pops at the clock edge and the next head appears the following cycle.
- Push and pop in the same cycle: both happen and occupancy is unchanged.
- Pop from an empty FIFO is impossible (out_write is gated by out_valid).
- Push when occupancy==OUT_DEPTH cannot occur (reservation). An assertion flags it in simulation.
- Pointer wrap: the FIFO read/write pointers are OUT_ADDRSIZE+1 bits with MSB wrap; full/empty are derived by comparison.
- down_full held high: the FIFO fills to OUT_DEPTH, then read_en stays 0; req is not consumed.
- Reset mid-operation: an in-flight flit whose VC was already popped is discarded; FIFO contents are discarded.
- Throughput: 1 flit/cycle sustained with down_full=0 and continuous req.

Optional Feature:
- Macro: OUTPUT_MODULE_STATS_EN.
- Defined: adds output port flit_count (16 bits), counting out_write pulses, and stall_count (16 bits), counting cycles with out_valid & down_full.
  - Both saturate at 16'hFFFF.
  - Both clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package noc_pkg: direction codes N/S/E/W/L/INVALID (3 bits), DSIZE default, port count 5.
- Sub-module output_fifo (parameters DSIZE, OUT_ADDRSIZE): push, pop, data in/out, count, full, empty.
- The arbiter stays inline because of the PORT mask and reservation gating.

Test Plan:
- Single flit: PORT=2 (E), req=5'b00001 for 1 cycle, data N=32'hA5A5_0001 → read_en=00001 at t; out_valid=1 at t+2 with data_out=A5A5_0001; out_write=1 the same cycle (down_full=0).
- Fairness: req=5'b11011 held, PORT=2 → grant order N, S, W, L, N, ...; E is never granted; one grant per cycle.
- Back-pressure: down_full=1, continuous req=00001 → exactly OUT_DEPTH (4) read_en pulses, then read_en=0 and occupancy=4. Release down_full → 4 flits leave in order on consecutive cycles.
- Simultaneous push/pop at occupancy=2 with down_full=0 → occupancy stays 2; flit order is preserved.
- Reset asserted one cycle after a grant → no push occurs; out_valid=0, occupancy=0, and pointer=0 the cycle after reset.
- OUTPUT_MODULE_STATS_EN: 10 transfers plus 3 stall cycles → flit_count=10, stall_count=3.
